// File: rtl/frame_renderer_pkg.sv
// Shared constants and types for the frame renderer.
//   SCREEN_W/SCREEN_H  : raster dimensions
//   SHIP_*/HP_PX       : sprite geometry and health-bar scale
//   COL_*              : 3-bit RGB colour codes
//   state_t            : frame FSM encoding
package frame_renderer_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int NPIX     = SCREEN_W * SCREEN_H;
    localparam int SHIP_W   = 8;
    localparam int SHIP_H   = 4;
    localparam int SHIP_Y   = 112;
    localparam int HP_PX    = 4;

    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_RED    = 3'b100;
    localparam logic [2:0] COL_GREEN  = 3'b010;
    localparam logic [2:0] COL_YELLOW = 3'b110;
    localparam logic [2:0] COL_WHITE  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/frame_renderer_pixel_classifier.sv
// Combinational colour decision for one pixel of the snapshot.
//   cx, cy   : pixel column / row
//   grid     : bullet map, bit (cy*SCREEN_W + cx)
//   user_x   : left column of user ship
//   enemy_x  : left column of enemy ship
//   hp       : ship health 0..15
//   colour   : resulting 3-bit colour
// Priority: health bar > user ship > enemy ship > bullet > black.
module frame_renderer_pixel_classifier
    import frame_renderer_pkg::*;
(
    input  logic [7:0]      cx,
    input  logic [6:0]      cy,
    input  logic [NPIX-1:0] grid,
    input  logic [7:0]      user_x,
    input  logic [7:0]      enemy_x,
    input  logic [3:0]      hp,
    output logic [2:0]      colour
);

    localparam logic [6:0] HP_PX7 = 7'(HP_PX);

    logic [6:0]  bar_len;
    logic [8:0]  user_end;
    logic [8:0]  enemy_end;
    logic [14:0] bit_idx;
    logic        in_bar;
    logic        in_user;
    logic        in_enemy;
    logic        is_bullet;

    // Right edges in 9 bits so a sprite near column 159 clips instead of wrapping.
    assign bar_len   = {3'b000, hp} * HP_PX7;
    assign user_end  = {1'b0, user_x}  + 9'(SHIP_W);
    assign enemy_end = {1'b0, enemy_x} + 9'(SHIP_W);
    assign bit_idx   = {8'b0, cy} * 15'(SCREEN_W) + {7'b0, cx};

    assign in_bar    = (cy == 7'(SCREEN_H - 1)) && (cx < {1'b0, bar_len});
    assign in_user   = (user_x < 8'(SCREEN_W)) && (cx >= user_x) && ({1'b0, cx} < user_end)
                       && (cy >= 7'(SHIP_Y)) && (cy < 7'(SHIP_Y + SHIP_H));
    assign in_enemy  = (enemy_x < 8'(SCREEN_W)) && (cx >= enemy_x) && ({1'b0, cx} < enemy_end)
                       && (cy < 7'(SHIP_H));
    assign is_bullet = grid[bit_idx];

    always_comb begin
        colour = COL_BLACK;
        if (in_bar)
            colour = COL_YELLOW;
        else if (in_user)
            colour = COL_GREEN;
        else if (in_enemy)
            colour = COL_RED;
        else if (is_bullet)
            colour = COL_WHITE;
    end

endmodule

// File: rtl/frame_renderer.sv
// Raster renderer feeding the VGA adapter write port.
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : draw request, sampled only when idle
//   grid                  : 160x120 bullet map
//   user_x, enemy_x       : sprite left columns
//   ship_health           : health 0..15
//   x, y, colour, plot    : registered pixel write
//   busy                  : frame in progress
//   done                  : one-cycle pulse after the last pixel
// A start snapshots all scene inputs; the frame is then scanned one pixel
// per clock from the snapshot, so inputs may change freely mid-frame.
module frame_renderer
    import frame_renderer_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [NPIX-1:0] grid,
    input  logic [7:0]      user_x,
    input  logic [7:0]      enemy_x,
    input  logic [3:0]      ship_health,
    output logic [7:0]      x,
    output logic [6:0]      y,
    output logic [2:0]      colour,
    output logic            plot,
    output logic            busy,
    output logic            done
);

    state_t state, state_nxt;

    logic [NPIX-1:0] grid_s;
    logic [7:0]      user_x_s;
    logic [7:0]      enemy_x_s;
    logic [3:0]      hp_s;

    logic [7:0] cx_p0;
    logic [6:0] cy_p0;
    logic [2:0] colour_p0;
    logic       last_px;
    logic       accept;

    logic [7:0] x_p1;
    logic [6:0] y_p1;
    logic [2:0] colour_p1;
    logic       vld_p1;
    logic       busy_p1;
    logic       done_p1;

    assign last_px = (cx_p0 == 8'(SCREEN_W - 1)) && (cy_p0 == 7'(SCREEN_H - 1));
    assign accept  = (state == IDLE) && start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DRAW;
            DRAW:    if (last_px) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: snapshot capture and scan counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grid_s    <= '0;
            user_x_s  <= '0;
            enemy_x_s <= '0;
            hp_s      <= '0;
            cx_p0     <= '0;
            cy_p0     <= '0;
        end else if (accept) begin
            grid_s    <= grid;
            user_x_s  <= user_x;
            enemy_x_s <= enemy_x;
            hp_s      <= ship_health;
            cx_p0     <= '0;
            cy_p0     <= '0;
        end else if (state == DRAW) begin
            if (cx_p0 == 8'(SCREEN_W - 1)) begin
                cx_p0 <= '0;
                cy_p0 <= cy_p0 + 7'd1;
            end else begin
                cx_p0 <= cx_p0 + 8'd1;
            end
        end
    end

    frame_renderer_pixel_classifier u_classifier (
        .cx      (cx_p0),
        .cy      (cy_p0),
        .grid    (grid_s),
        .user_x  (user_x_s),
        .enemy_x (enemy_x_s),
        .hp      (hp_s),
        .colour  (colour_p0)
    );

    // Stage p1: registered pixel write and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_p1      <= '0;
            y_p1      <= '0;
            colour_p1 <= '0;
            vld_p1    <= 1'b0;
            busy_p1   <= 1'b0;
            done_p1   <= 1'b0;
        end else begin
            vld_p1  <= (state == DRAW);
            busy_p1 <= accept || (state == DRAW);
            done_p1 <= (state == DONE);
            if (state == DRAW) begin
                x_p1      <= cx_p0;
                y_p1      <= cy_p0;
                colour_p1 <= colour_p0;
            end
        end
    end

    assign x      = x_p1;
    assign y      = y_p1;
    assign colour = colour_p1;
    assign plot   = vld_p1;
    assign busy   = busy_p1;
    assign done   = done_p1;

endmodule

// File: tb/tb_frame_renderer.sv
// Directed self-checking bench for frame_renderer.
module tb_frame_renderer;

    localparam int NPIX = 19200;

    logic            clk;
    logic            reset;
    logic            start;
    logic [NPIX-1:0] grid;
    logic [7:0]      user_x;
    logic [7:0]      enemy_x;
    logic [3:0]      ship_health;
    logic [7:0]      x;
    logic [6:0]      y;
    logic [2:0]      colour;
    logic            plot;
    logic            busy;
    logic            done;

    int total;
    int bad;

    logic [2:0] fb [0:NPIX-1];
    int plot_cnt, order_err, gap_err, done_k, first_plot_k, last_plot_k;
    logic busy_start, busy_at_done, plot_at_done;

    frame_renderer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .grid        (grid),
        .user_x      (user_x),
        .enemy_x     (enemy_x),
        .ship_health (ship_health),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pix(input int px, input int py);
        return py * 160 + px;
    endfunction

    function automatic int count_col(input logic [2:0] c);
        int n = 0;
        for (int i = 0; i < NPIX; i++)
            if (fb[i] === c) n++;
        return n;
    endfunction

    // Issue a start, then record every plotted pixel until done or timeout.
    // k counts clock edges after the capturing edge.
    task automatic run_frame(input bit hold, input bit mutate);
        int ex, ey;
        for (int i = 0; i < NPIX; i++) fb[i] = 3'b101;
        plot_cnt = 0; order_err = 0; gap_err = 0;
        done_k = -1; first_plot_k = -1; last_plot_k = -1;
        busy_at_done = 1'bx; plot_at_done = 1'bx;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        busy_start = busy;
        if (!hold) start = 1'b0;
        ex = 0; ey = 0;
        for (int k = 1; k <= 20000; k++) begin
            if (mutate && k == 100) begin
                user_x = 8'd50;
                grid   = '1;
            end
            @(posedge clk); #1;
            if (plot) begin
                if (plot_cnt == 0) first_plot_k = k;
                if (k != plot_cnt + 1) gap_err++;
                if (x !== 8'(ex) || y !== 7'(ey)) order_err++;
                if (int'(x) < 160 && int'(y) < 120) fb[pix(int'(x), int'(y))] = colour;
                plot_cnt++;
                last_plot_k = k;
                if (ex == 159) begin ex = 0; ey++; end else ex++;
            end
            if (done) begin
                done_k = k;
                busy_at_done = busy;
                plot_at_done = plot;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; grid = '0;
        user_x = 8'd0; enemy_x = 8'd0; ship_health = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({x, y, colour, plot, busy, done} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {x, y, colour, plot, busy, done});
        end
        @(negedge clk); reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if ({plot, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL idle_no_start got=%b want=000", {plot, busy, done});
        end
    endtask

    task automatic test_basic;
        int idx [9];
        logic [2:0] want [9];
        grid = '0; grid[50*160+80] = 1'b1;
        user_x = 8'd0; enemy_x = 8'd0; ship_health = 4'd0;
        run_frame(1'b0, 1'b0);
        total++; if (plot_cnt !== 19200) begin bad++; $display("FAIL basic_plot_count got=%0d want=19200", plot_cnt); end
        total++; if (gap_err !== 0) begin bad++; $display("FAIL basic_contiguous got=%0d want=0", gap_err); end
        total++; if (order_err !== 0) begin bad++; $display("FAIL basic_scan_order got=%0d want=0", order_err); end
        total++; if (first_plot_k !== 1) begin bad++; $display("FAIL basic_first_plot got=%0d want=1", first_plot_k); end
        total++; if (last_plot_k !== 19200) begin bad++; $display("FAIL basic_last_plot got=%0d want=19200", last_plot_k); end
        total++; if (done_k !== 19201) begin bad++; $display("FAIL basic_done_cycle got=%0d want=19201", done_k); end
        total++; if (busy_start !== 1'b1) begin bad++; $display("FAIL basic_busy_rise got=%b want=1", busy_start); end
        total++; if ({busy_at_done, plot_at_done} !== 2'b00) begin bad++; $display("FAIL basic_done_flags got=%b want=00", {busy_at_done, plot_at_done}); end
        idx[0] = pix(0, 0);    want[0] = 3'b100;
        idx[1] = pix(7, 3);    want[1] = 3'b100;
        idx[2] = pix(8, 0);    want[2] = 3'b000;
        idx[3] = pix(0, 4);    want[3] = 3'b000;
        idx[4] = pix(0, 112);  want[4] = 3'b010;
        idx[5] = pix(100, 50); want[5] = 3'b000;
        idx[6] = pix(80, 50);  want[6] = 3'b111;
        idx[7] = pix(0, 119);  want[7] = 3'b000;
        idx[8] = pix(7, 115);  want[8] = 3'b010;
        for (int i = 0; i < 9; i++) begin
            total++;
            if (fb[idx[i]] !== want[i]) begin
                bad++;
                $display("FAIL basic_pixel(%0d,%0d) got=%b want=%b", idx[i] % 160, idx[i] / 160, fb[idx[i]], want[i]);
            end
        end
        total++; if (count_col(3'b111) !== 1) begin bad++; $display("FAIL basic_white_count got=%0d want=1", count_col(3'b111)); end
    endtask

    task automatic test_clip;
        int idx [8];
        logic [2:0] want [8];
        grid = '0; user_x = 8'd156; enemy_x = 8'd200; ship_health = 4'd15;
        run_frame(1'b0, 1'b0);
        total++; if (plot_cnt !== 19200) begin bad++; $display("FAIL clip_plot_count got=%0d want=19200", plot_cnt); end
        idx[0] = pix(156, 112); want[0] = 3'b010;
        idx[1] = pix(159, 115); want[1] = 3'b010;
        idx[2] = pix(0, 112);   want[2] = 3'b000;
        idx[3] = pix(155, 112); want[3] = 3'b000;
        idx[4] = pix(156, 116); want[4] = 3'b000;
        idx[5] = pix(0, 119);   want[5] = 3'b110;
        idx[6] = pix(59, 119);  want[6] = 3'b110;
        idx[7] = pix(60, 119);  want[7] = 3'b000;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (fb[idx[i]] !== want[i]) begin
                bad++;
                $display("FAIL clip_pixel(%0d,%0d) got=%b want=%b", idx[i] % 160, idx[i] / 160, fb[idx[i]], want[i]);
            end
        end
        total++; if (count_col(3'b100) !== 0) begin bad++; $display("FAIL clip_red_count got=%0d want=0", count_col(3'b100)); end
        total++; if (count_col(3'b010) !== 16) begin bad++; $display("FAIL clip_green_count got=%0d want=16", count_col(3'b010)); end
        total++; if (count_col(3'b110) !== 60) begin bad++; $display("FAIL clip_yellow_count got=%0d want=60", count_col(3'b110)); end
    endtask

    // start stays high for the whole frame; inputs change mid-frame.
    task automatic test_hold_priority;
        int idx [7];
        logic [2:0] want [7];
        grid = '0; grid[1*160+2] = 1'b1; grid[119*160+0] = 1'b1;
        user_x = 8'd0; enemy_x = 8'd0; ship_health = 4'd1;
        run_frame(1'b1, 1'b1);
        total++; if (plot_cnt !== 19200) begin bad++; $display("FAIL hold_plot_count got=%0d want=19200", plot_cnt); end
        total++; if (done_k !== 19201) begin bad++; $display("FAIL hold_done_cycle got=%0d want=19201", done_k); end
        idx[0] = pix(2, 1);    want[0] = 3'b100;
        idx[1] = pix(0, 119);  want[1] = 3'b110;
        idx[2] = pix(3, 119);  want[2] = 3'b110;
        idx[3] = pix(4, 119);  want[3] = 3'b000;
        idx[4] = pix(0, 112);  want[4] = 3'b010;
        idx[5] = pix(50, 112); want[5] = 3'b000;
        idx[6] = pix(60, 60);  want[6] = 3'b000;
        for (int i = 0; i < 7; i++) begin
            total++;
            if (fb[idx[i]] !== want[i]) begin
                bad++;
                $display("FAIL hold_pixel(%0d,%0d) got=%b want=%b", idx[i] % 160, idx[i] / 160, fb[idx[i]], want[i]);
            end
        end
        total++; if (count_col(3'b111) !== 0) begin bad++; $display("FAIL hold_white_count got=%0d want=0", count_col(3'b111)); end
    endtask

    // Second frame starts from the held start; reset lands at its 5000th plot.
    task automatic test_back_to_back_reset;
        int cnt, ex, ey, oerr, seen_done;
        cnt = 0; ex = 0; ey = 0; oerr = 0; seen_done = 0;
        for (int i = 0; i < NPIX; i++) fb[i] = 3'b101;
        @(posedge clk); #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_after_done got=%b want=1", busy); end
        for (int k = 1; k <= 6000 && cnt < 5000; k++) begin
            @(posedge clk); #1;
            if (plot) begin
                if (x !== 8'(ex) || y !== 7'(ey)) oerr++;
                if (int'(x) < 160 && int'(y) < 120) fb[pix(int'(x), int'(y))] = colour;
                cnt++;
                if (ex == 159) begin ex = 0; ey++; end else ex++;
            end
        end
        total++; if (cnt !== 5000) begin bad++; $display("FAIL b2b_reached_5000 got=%0d want=5000", cnt); end
        total++; if (oerr !== 0) begin bad++; $display("FAIL b2b_scan_order got=%0d want=0", oerr); end
        total++; if (fb[pix(60, 20)] !== 3'b111) begin bad++; $display("FAIL b2b_new_grid got=%b want=111", fb[pix(60, 20)]); end
        total++; if (fb[pix(0, 0)] !== 3'b100) begin bad++; $display("FAIL b2b_enemy got=%b want=100", fb[pix(0, 0)]); end
        start = 1'b0;
        reset = 1'b1;
        #1;
        total++; if (plot !== 1'b0) begin bad++; $display("FAIL rst_plot_drop got=%b want=0", plot); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy_drop got=%b want=0", busy); end
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done || plot) seen_done++;
        end
        total++; if (seen_done !== 0) begin bad++; $display("FAIL rst_no_done got=%0d want=0", seen_done); end
        grid = '0; user_x = 8'd100; enemy_x = 8'd20; ship_health = 4'd0;
        run_frame(1'b0, 1'b0);
        total++; if (plot_cnt !== 19200) begin bad++; $display("FAIL rst_refresh_count got=%0d want=19200", plot_cnt); end
        total++; if (order_err !== 0 || first_plot_k !== 1) begin bad++; $display("FAIL rst_refresh_start got=%0d/%0d want=0/1", order_err, first_plot_k); end
        total++; if (done_k !== 19201) begin bad++; $display("FAIL rst_refresh_done got=%0d want=19201", done_k); end
        total++; if (fb[pix(100, 112)] !== 3'b010) begin bad++; $display("FAIL rst_refresh_user got=%b want=010", fb[pix(100, 112)]); end
        total++; if (fb[pix(27, 3)] !== 3'b100) begin bad++; $display("FAIL rst_refresh_enemy got=%b want=100", fb[pix(27, 3)]); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_basic;
        test_clip;
        test_hold_priority;
        test_back_to_back_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_renderer.md
Name: frame_renderer

Overview:
- Downstream consumer of the game datapath. On each draw request it snapshots the 160x120 bullet grid, user_x, enemy_x and ship_health.
- It then raster-scans the snapshot one pixel per clock and emits x/y/colour/plot to the VGA adapter's write port.
- It composes ship and enemy sprites, bullets and a health bar into 3-bit colour, with a fixed priority order.

Parameters:
- SCREEN_W, 160, pixels per row
- SCREEN_H, 120, rows per frame
- SHIP_W, 8, user/enemy sprite width in pixels
- SHIP_H, 4, user/enemy sprite height in rows
- SHIP_Y, 112, top row of user ship
- HP_PX, 4, health-bar pixels per health point

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- start  in  1  draw request; sampled only in IDLE
- grid  in  SCREEN_W*SCREEN_H  bullet map; bit (y*160 + x) set = bullet at (x,y)
- user_x  in  8  left column of user ship
- enemy_x  in  8  left column of enemy ship
- ship_health  in  4  current health, 0..15
- x  out  8  pixel column to plot
- y  out  7  pixel row to plot
- colour  out  3  RGB colour of pixel
- plot  out  1  write strobe to VGA adapter
- busy  out  1  high from snapshot until the last pixel is issued
- done  out  1  one-cycle pulse after the frame completes

Behaviour:
- Reset values (asynchronous): state=IDLE; x=0, y=0, colour=0, plot=0, busy=0, done=0; snapshot registers cleared.
- FSM states: IDLE, DRAW, DONE.
- IDLE:
  - start=1 at edge N: capture grid, user_x, enemy_x, ship_health into snapshot registers; clear scan counters to (0,0); go to DRAW; busy=1 from cycle N+1.
  - start=0: stay in IDLE.
- DRAW, one pixel per cycle:
  - Outputs are registered. The pixel for counter (cx,cy) appears on x/y/colour with plot=1 one cycle after the counter holds it.
  - First plot of (0,0) is at cycle N+2.
  - cx increments 0..159. At cx=159, cx wraps to 0 and cy increments. After (159,119) the FSM goes to DONE.
  - Exactly 19200 plot cycles, contiguous.
- DONE: lasts one cycle. plot=0, busy=0, done=1. Returns to IDLE. A new start can be accepted on the following cycle.
- start while busy (DRAW or DONE) is ignored and is not queued.
- Input changes during DRAW have no effect; all colour decisions use the snapshot only.
- Colour priority, highest first:
  1. Health bar: cy=119 and cx < hp*HP_PX → yellow 3'b110.
  2. User ship: user_x <= cx < user_x+SHIP_W and SHIP_Y <= cy < SHIP_Y+SHIP_H → green 3'b010.
  3. Enemy ship: enemy_x <= cx < enemy_x+SHIP_W and cy < SHIP_H → red 3'b100.
  4. Bullet: grid bit (cy*160+cx)=1 → white 3'b111.
  5. Otherwise black 3'b000.
- Width rules:
  - Sprite right edges are computed in 9 bits, so no wrap-around. Sprites with x >= 153 are clipped at column 159.
  - user_x/enemy_x >= 160 draw no sprite.
  - hp*HP_PX is computed in 7 bits; health 0 draws no bar.
- Reset mid-frame: plot drops to 0 immediately (asynchronous); the FSM returns to IDLE; no done pulse is issued.
- Total latency from start to done = 19202 cycles.

Decomposition:
- Shared package:
  - SCREEN_W, SCREEN_H.
  - Colour constants COL_BLACK, COL_RED, COL_GREEN, COL_YELLOW, COL_WHITE.
  - State encoding for IDLE/DRAW/DONE.
- One combinational sub-module, pixel_classifier. Inputs: cx, cy, snapshot fields. Output: colour. It keeps the priority logic separately testable.
- The FSM, scan counters, snapshot and output registers remain in frame_renderer.

Test Plan:
- Reset, then start pulse with grid all zero, user_x=0, enemy_x=0, health=0. Expect:
  - 19200 plots.
  - (0,0) red, (0,112) green, (100,50) black.
  - done one cycle after the (159,119) plot, at 19202 cycles after start.
- Grid bit 50*160+80 set, ship/enemy at x=0, health=0 → (80,50) white; all other bullet-area pixels black.
- user_x=156, enemy_x=200, health=15 → green at columns 156..159 of rows 112..115 with no wrap to column 0; no red anywhere; row 119 yellow for cx 0..59, black at cx=60.
- Overlap priority: bullet bit at (2,1) with enemy_x=0 → red at (2,1). Bullet at (0,119), user_x=0, health=1 → yellow at (0,119).
- Hold start high throughout and change grid/user_x mid-frame → exactly one 19200-plot frame using start-time values; second frame begins on the cycle after done.
- Assert reset at the 5000th plot → plot=0 the same cycle, no done pulse, busy=0; a new start produces a full frame beginning at (0,0).
